// File: rtl/dmem_pkg.sv
// Shared types and helpers for the two-requester data-memory arbiter.
package dmem_pkg;

  // Access size encoding, shared by requesters and the memory port.
  typedef enum logic [1:0] {
    WORD    = 2'b00,
    HALF    = 2'b01,
    BYTE    = 2'b10,
    ILLEGAL = 2'b11
  } size_e;

  // Arbiter sequencing: one access occupies IDLE -> ACCESS -> RESP.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  localparam int N_REQ = 2;

  // Misaligned halves/words and the reserved size code never reach memory.
  function automatic logic is_illegal(input size_e size, input logic [1:0] addr_lo);
    case (size)
      WORD:    return addr_lo != 2'b00;
      HALF:    return addr_lo[0];
      BYTE:    return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Pick the memory read lane matching the access size, zero-extended.
  function automatic logic [31:0] load_extend(input size_e size,
                                              input logic [31:0] rd_word,
                                              input logic [15:0] rd_half,
                                              input logic [7:0] rd_byte);
    case (size)
      WORD:    return rd_word;
      HALF:    return {16'h0000, rd_half};
      BYTE:    return {24'h000000, rd_byte};
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two request lanes plus
// a shared response data bus.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]             m_valid;
  logic [1:0]             m_ready;
  logic [1:0]             m_we;
  logic [1:0][1:0]        m_size;
  logic [1:0][ADDR_W-1:0] m_addr;
  logic [1:0][DATA_W-1:0] m_wdata;
  logic [1:0]             m_rvalid;
  logic [1:0]             m_err;
  logic [DATA_W-1:0]      m_rdata;

  // Requesters drive requests and observe accepts/responses.
  modport master (
    output m_valid, m_we, m_size, m_addr, m_wdata,
    input  m_ready, m_rvalid, m_err, m_rdata
  );

  // The arbiter consumes requests and produces accepts/responses.
  modport slave (
    input  m_valid, m_we, m_size, m_addr, m_wdata,
    output m_ready, m_rvalid, m_err, m_rdata
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on contention the requester that did not
// win last time is chosen; a lone request always wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot (or zero) grant from the request pair and last winner.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one memory port between the core LSU
// (requester 0) and the debug/DMA port (requester 1). Each access takes
// three cycles: accept, memory access, response.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  dmem_arbiter_if.slave     bus,
  output logic              mem_memwrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_load_type,
  output logic [1:0]        mem_store_type,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [31:0]       mem_rdata_word,
  input  logic [15:0]       mem_rdata_half,
  input  logic [7:0]        mem_rdata_byte
);

  state_e              state_reg;
  logic                last_grant_reg;
  logic                gnt_id_reg;
  logic                we_reg;
  size_e               size_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic                illegal_reg;
  logic                memwrite_reg;
  logic [1:0]          rvalid_reg;
  logic [1:0]          err_reg;
  logic [DATA_W-1:0]   rdata_reg;

  logic [1:0]          grant;
  logic                sel_id;
  size_e               sel_size;
  logic                sel_illegal;

  rr_arb2 u_rr_arb2 (
    .req        (bus.m_valid),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  // Decode the winning lane and pre-check its legality for the accept edge.
  always_comb begin
    sel_id      = grant[1];
    sel_size    = size_e'(bus.m_size[sel_id]);
    sel_illegal = is_illegal(sel_size, bus.m_addr[sel_id][1:0]);
  end

  // Accept is only offered while idle; the response and write strobes are
  // also masked by reset so an abandoned transaction has no visible effect
  // in the cycle reset is asserted.
  assign bus.m_ready    = (state_reg == IDLE && resetn) ? grant : 2'b00;
  assign bus.m_rvalid   = resetn ? rvalid_reg : 2'b00;
  assign bus.m_err      = resetn ? err_reg : 2'b00;
  assign bus.m_rdata    = rdata_reg;
  assign mem_memwrite   = memwrite_reg & resetn;
  assign mem_addr       = addr_reg;
  assign mem_wdata      = wdata_reg;
  assign mem_load_type  = size_reg;
  assign mem_store_type = size_reg;

  // Sequencer: latch the granted request, run the memory access, respond.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      gnt_id_reg     <= 1'b0;
      we_reg         <= 1'b0;
      size_reg       <= WORD;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      illegal_reg    <= 1'b0;
      memwrite_reg   <= 1'b0;
      rvalid_reg     <= 2'b00;
      err_reg        <= 2'b00;
      rdata_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|bus.m_valid) begin
            state_reg      <= ACCESS;
            last_grant_reg <= sel_id;
            gnt_id_reg     <= sel_id;
            we_reg         <= bus.m_we[sel_id];
            size_reg       <= sel_size;
            addr_reg       <= bus.m_addr[sel_id];
            wdata_reg      <= bus.m_wdata[sel_id];
            illegal_reg    <= sel_illegal;
            memwrite_reg   <= bus.m_we[sel_id] & ~sel_illegal;
          end
        end
        ACCESS: begin
          state_reg    <= RESP;
          memwrite_reg <= 1'b0;
          rvalid_reg   <= gnt_id_reg ? 2'b10 : 2'b01;
          err_reg      <= illegal_reg ? (gnt_id_reg ? 2'b10 : 2'b01) : 2'b00;
          if (illegal_reg || we_reg) begin
            rdata_reg <= '0;
          end else begin
            rdata_reg <= load_extend(size_reg, mem_rdata_word, mem_rdata_half, mem_rdata_byte);
          end
        end
        RESP: begin
          state_reg  <= IDLE;
          rvalid_reg <= 2'b00;
          err_reg    <= 2'b00;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
